// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-addressed RAM between instruction fetch (IF) and data (D) ports.
// Sequences the enable/MOC handshake, aligns byte data and flags misaligned, out-of-range or timed-out accesses.
// Optional feature: define ROUND_ROBIN_EN to alternate grants on simultaneous requests
// (default build: fixed D-over-IF priority).
module mem_port_arbiter #(
  parameter int unsigned MEM_BYTES   = 512,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        d_req_i,
  input  logic        d_rw_i,
  input  logic        d_byte_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        err_o,
  output logic        mem_en_o,
  output logic        mem_rw_o,
  output logic        mem_byte_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_moc_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, BUSY, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;   // 1 = D port owns the current access
  logic                   rw_q, rw_d;
  logic                   byte_q, byte_d;
  logic                   en_q, en_d;
  logic                   if_ack_q, if_ack_d;
  logic                   d_ack_q, d_ack_d;
  logic                   err_q, err_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] moc_sync_q;
  logic                   moc_s;

  logic                   grant_c;
  logic                   pick_c;             // 1 = grant goes to D
  logic                   sel_byte_c;
  logic [31:0]            sel_addr_c;
  logic [32:0]            last_byte_c;
  logic                   bad_c;

  assign moc_s = moc_sync_q[SYNC_STAGES-1];

  // MOC synchronizer; idles high so a reset RAM reads as "done"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) moc_sync_q <= '1;
    else        moc_sync_q <= {moc_sync_q[SYNC_STAGES-2:0], mem_moc_i};
  end

`ifdef ROUND_ROBIN_EN
  logic last_q;  // 1 = D was served last

  // Remember who won the most recent grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_q <= 1'b0;
    else if (grant_c) last_q <= pick_c;
  end

  // Ties go to the requester not served last
  always_comb begin
    pick_c = d_req_i;
    if (d_req_i && if_req_i) pick_c = ~last_q;
  end
`else
  // Fixed priority: D always wins
  always_comb begin
    pick_c = d_req_i;
  end
`endif

  // Grant selection and access legality check on the winner's fields
  always_comb begin
    grant_c     = (state_q == IDLE) && (d_req_i || if_req_i);
    sel_byte_c  = pick_c ? d_byte_i : 1'b0;
    sel_addr_c  = pick_c ? d_addr_i : if_addr_i;
    last_byte_c = {1'b0, sel_addr_c} + (sel_byte_c ? 33'd0 : 33'd3);
    bad_c       = (!sel_byte_c && (sel_addr_c[1:0] != 2'b00)) ||
                  (last_byte_c >= 33'(MEM_BYTES));
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rw_q     <= 1'b0;
      byte_q   <= 1'b0;
      en_q     <= 1'b0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rw_q     <= rw_d;
      byte_q   <= byte_d;
      en_q     <= en_d;
      if_ack_q <= if_ack_d;
      d_ack_q  <= d_ack_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and next-output logic for the access sequencer
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rw_d     = rw_q;
    byte_d   = byte_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    en_d     = 1'b0;
    err_d    = 1'b0;
    if_ack_d = 1'b0;
    d_ack_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_c) begin
          owner_d = pick_c;
          rw_d    = pick_c ? d_rw_i : 1'b0;
          byte_d  = sel_byte_c;
          addr_d  = sel_addr_c;
          wdata_d = !pick_c ? 32'd0 :
                    d_byte_i ? {d_wdata_i[7:0], 24'd0} : d_wdata_i;
          rdata_d = '0;
          if (bad_c) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = STROBE;
        en_d    = 1'b1;
        cnt_d   = '0;
      end
      STROBE: begin
        en_d = 1'b1;
        if (!moc_s) begin
          state_d = BUSY;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BUSY: begin
        en_d = 1'b1;
        if (moc_s) begin
          state_d = RESP;
          en_d    = 1'b0;
          rdata_d = byte_q ? {24'd0, mem_rdata_i[31:24]} : mem_rdata_i;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Exactly one ack accompanies the RESP cycle
    if (state_d == RESP) begin
      if_ack_d = ~owner_d;
      d_ack_d  = owner_d;
    end
  end

  assign if_rdata_o  = rdata_q;
  assign d_rdata_o   = rdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign err_o       = err_q;
  assign mem_en_o    = en_q;
  assign mem_rw_o    = rw_q;
  assign mem_byte_o  = byte_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a behavioural MOC-handshake RAM.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned MEM_BYTES = 512;
  localparam int unsigned TIMEOUT   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b0;
  logic        d_byte = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic        mem_en;
  logic        mem_rw;
  logic        mem_byte;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_moc = 1'b1;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .d_req_i(d_req), .d_rw_i(d_rw), .d_byte_i(d_byte), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_ack_o(d_ack), .err_o(err),
    .mem_en_o(mem_en), .mem_rw_o(mem_rw), .mem_byte_o(mem_byte), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_moc_i(mem_moc)
  );

  // Behavioural RAM: big-endian bytes, MOC drops one cycle after mem_en rises, stays low ram_low cycles
  logic [7:0]  ram [MEM_BYTES];
  int          ram_low = 13;
  bit          ram_hang = 1'b0;
  int          ram_phase = 0;
  int          ram_cnt = 0;
  logic        en_prev_ram = 1'b0;
  logic [31:0] ram_last_wdata = '0;

  always @(posedge clk) begin
    en_prev_ram <= mem_en;
    if (!mem_en) begin
      ram_phase <= 0;
      mem_moc   <= 1'b1;
    end else begin
      case (ram_phase)
        0: if (!en_prev_ram) begin
             ram_phase <= ram_hang ? 3 : 1;
             ram_cnt   <= 1;
           end
        1: if (ram_cnt <= 1) begin
             mem_moc   <= 1'b0;
             ram_cnt   <= ram_low;
             ram_phase <= 2;
           end else ram_cnt <= ram_cnt - 1;
        2: if (ram_cnt <= 1) begin
             if (mem_rw) begin
               ram_last_wdata <= mem_wdata;
               ram[mem_addr[8:0]] <= mem_wdata[31:24];
               if (!mem_byte) begin
                 ram[mem_addr[8:0] + 9'd1] <= mem_wdata[23:16];
                 ram[mem_addr[8:0] + 9'd2] <= mem_wdata[15:8];
                 ram[mem_addr[8:0] + 9'd3] <= mem_wdata[7:0];
               end
             end else if (mem_byte) begin
               mem_rdata <= {ram[mem_addr[8:0]], 24'hABCDEF};
             end else begin
               mem_rdata <= {ram[mem_addr[8:0]], ram[mem_addr[8:0] + 9'd1],
                             ram[mem_addr[8:0] + 9'd2], ram[mem_addr[8:0] + 9'd3]};
             end
             mem_moc   <= 1'b1;
             ram_phase <= 3;
           end else ram_cnt <= ram_cnt - 1;
        default: ;
      endcase
    end
  end

  // Count mem_en rising edges
  int   en_rises = 0;
  logic en_prev_cnt = 1'b0;
  always @(posedge clk) begin
    en_prev_cnt <= mem_en;
    if (mem_en && !en_prev_cnt) en_rises <= en_rises + 1;
  end

  function automatic exp_t mk_exp(input logic is_d, input logic [31:0] rdata, input logic e);
    exp_t x;
    x.is_d  = is_d;
    x.rdata = rdata;
    x.err   = e;
    return x;
  endfunction

  // Waits (bounded) for any ack and returns what was seen on that cycle
  task automatic wait_ack(input int budget, output bit ok, output logic gi, output logic gd,
                          output logic ge, output logic [31:0] ri, output logic [31:0] rd);
    ok = 1'b0; gi = 1'b0; gd = 1'b0; ge = 1'b0; ri = '0; rd = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        ok = 1'b1; gi = if_ack; gd = d_ack; ge = err; ri = if_rdata; rd = d_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({if_ack, d_ack, err, mem_en} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {if_ack, d_ack, err, mem_en});
    end
    checks++;
    if ({mem_rw, mem_byte, mem_addr, mem_wdata} !== 66'd0) begin
      errors++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
    end
    checks++;
    if ({if_rdata, d_rdata} !== 64'd0) begin
      errors++; $display("FAIL reset_rdata: got %h/%h expected 0", if_rdata, d_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_if_read();
    bit ok; logic gi, gd, ge; logic [31:0] ri, rd; exp_t e;
    exp_q.push_back(mk_exp(1'b0, 32'h2002000A, 1'b0));
    if_addr = 32'h8; if_req = 1'b1;
    wait_ack(300, ok, gi, gd, ge, ri, rd);
    if_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!ok || gi !== 1'b1 || gd !== 1'b0) begin
      errors++; $display("FAIL if_read_ack: ok=%0b if_ack=%b d_ack=%b expected if_ack only", ok, gi, gd);
    end
    checks++;
    if (ri !== e.rdata || ge !== e.err) begin
      errors++; $display("FAIL if_read_data: got %h err=%b expected %h err=%b", ri, ge, e.rdata, e.err);
    end
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b0) begin
      errors++; $display("FAIL if_ack_pulse: got %b one cycle later expected 0", if_ack);
    end
  endtask

  task automatic test_byte_rw();
    bit ok; logic gi, gd, ge; logic [31:0] ri, rd; exp_t e;
    exp_q.push_back(mk_exp(1'b1, 32'h0, 1'b0));
    d_rw = 1'b1; d_byte = 1'b1; d_addr = 32'h10; d_wdata = 32'hAAAAAA41; d_req = 1'b1;
    wait_ack(300, ok, gi, gd, ge, ri, rd);
    d_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!ok || gd !== 1'b1 || gi !== 1'b0 || ge !== e.err) begin
      errors++; $display("FAIL byte_write_ack: ok=%0b d_ack=%b if_ack=%b err=%b", ok, gd, gi, ge);
    end
    checks++;
    if (ram_last_wdata !== 32'h41000000 || ram[16] !== 8'h41) begin
      errors++; $display("FAIL byte_write_data: got %h ram=%h expected 41000000/41", ram_last_wdata, ram[16]);
    end
    exp_q.push_back(mk_exp(1'b1, 32'h00000041, 1'b0));
    @(negedge clk);
    d_rw = 1'b0; d_req = 1'b1;
    wait_ack(300, ok, gi, gd, ge, ri, rd);
    d_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!ok || gd !== 1'b1 || rd !== e.rdata || ge !== e.err) begin
      errors++; $display("FAIL byte_read: ok=%0b got %h err=%b expected %h err=%b", ok, rd, ge, e.rdata, e.err);
    end
  endtask

  task automatic test_priority();
    bit ok; logic gi, gd, ge; logic [31:0] ri, rd; exp_t e; int rises0;
    {ram[32], ram[33], ram[34], ram[35]} = 32'hDEADBEEF;
    rises0 = en_rises;
    exp_q.push_back(mk_exp(1'b1, 32'hDEADBEEF, 1'b0));
    exp_q.push_back(mk_exp(1'b0, 32'h2002000A, 1'b0));
    d_rw = 1'b0; d_byte = 1'b0; d_addr = 32'h20; if_addr = 32'h8;
    d_req = 1'b1; if_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_ack(300, ok, gi, gd, ge, ri, rd);
      e = exp_q.pop_front();
      checks++;
      if (!ok || gd !== e.is_d || gi !== !e.is_d) begin
        errors++; $display("FAIL prio_order%0d: d_ack=%b if_ack=%b expected d_ack=%b", k, gd, gi, e.is_d);
      end
      checks++;
      if ((e.is_d ? rd : ri) !== e.rdata || ge !== e.err) begin
        errors++; $display("FAIL prio_data%0d: got %h expected %h", k, e.is_d ? rd : ri, e.rdata);
      end
      if (gd) d_req = 1'b0;
      if (gi) if_req = 1'b0;
    end
    d_req = 1'b0; if_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (en_rises - rises0 != 2) begin
      errors++; $display("FAIL prio_en_pulses: got %0d expected 2", en_rises - rises0);
    end
  endtask

`ifdef ROUND_ROBIN_EN
  task automatic test_round_robin();
    bit ok; logic gi, gd, ge; logic [31:0] ri, rd; exp_t e;
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk_exp((k % 2) == 0, (k % 2) == 0 ? 32'hDEADBEEF : 32'h2002000A, 1'b0));
    d_rw = 1'b0; d_byte = 1'b0; d_addr = 32'h20; if_addr = 32'h8;
    d_req = 1'b1; if_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(300, ok, gi, gd, ge, ri, rd);
      e = exp_q.pop_front();
      checks++;
      if (!ok || gd !== e.is_d || gi !== !e.is_d) begin
        errors++; $display("FAIL rr_order%0d: d_ack=%b if_ack=%b expected d_ack=%b", k, gd, gi, e.is_d);
      end
    end
    d_req = 1'b0; if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask
`endif

  task automatic test_errors();
    bit ok; logic gi, gd, ge; logic [31:0] ri, rd; exp_t e; int rises0;
    bit          t_byte [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] t_addr [6] = '{32'h6, 32'h1FE, 32'h200, 32'h1FC, 32'h1FF, 32'h200};
    bit          t_err  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] t_data [6] = '{32'h0, 32'h0, 32'h0, 32'h11223344, 32'h00000044, 32'h0};
    {ram[508], ram[509], ram[510], ram[511]} = 32'h11223344;
    for (int k = 0; k < 6; k++) begin
      rises0 = en_rises;
      exp_q.push_back(mk_exp(1'b1, t_data[k], t_err[k]));
      d_rw = 1'b0; d_byte = t_byte[k]; d_addr = t_addr[k]; d_req = 1'b1;
      wait_ack(300, ok, gi, gd, ge, ri, rd);
      d_req = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (!ok || gd !== 1'b1 || ge !== e.err) begin
        errors++; $display("FAIL range%0d_err: ok=%0b d_ack=%b err=%b expected err=%b", k, ok, gd, ge, e.err);
      end
      checks++;
      if (rd !== e.rdata) begin
        errors++; $display("FAIL range%0d_data: got %h expected %h", k, rd, e.rdata);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (en_rises - rises0 != (e.err ? 0 : 1)) begin
        errors++; $display("FAIL range%0d_en: got %0d pulses expected %0d", k, en_rises - rises0, e.err ? 0 : 1);
      end
    end
  endtask

  task automatic test_timeout();
    int n; bit seen;
    ram_hang = 1'b1;
    d_rw = 1'b0; d_byte = 1'b0; d_addr = 32'h20; d_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = mem_en;
    end
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (d_ack || if_ack) break;
    end
    d_req = 1'b0;
    checks++;
    if (!seen || n != TIMEOUT) begin
      errors++; $display("FAIL timeout_cycles: got %0d expected %0d", n, TIMEOUT);
    end
    checks++;
    if (d_ack !== 1'b1 || err !== 1'b1 || d_rdata !== 32'd0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL timeout_resp: d_ack=%b err=%b rdata=%h mem_en=%b expected 1 1 0 0",
                         d_ack, err, d_rdata, mem_en);
    end
    ram_hang = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok, seen; logic gi, gd, ge; logic [31:0] ri, rd; exp_t e; int acks;
    ram_low = 30;
    d_rw = 1'b0; d_byte = 1'b0; d_addr = 32'h1FC; d_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = !mem_moc;
    end
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0; d_req = 1'b0;
    #1;
    checks++;
    if (!seen || {mem_en, if_ack, d_ack, err} !== 4'b0000) begin
      errors++; $display("FAIL reset_mid: got busy=%0b en/acks/err=%b expected 1/0000", seen, {mem_en, if_ack, d_ack, err});
    end
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if_ack || d_ack || mem_en) acks++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if_ack || d_ack || mem_en) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL reset_mid_discard: got %0d active cycles expected 0", acks);
    end
    ram_low = 13;
    exp_q.push_back(mk_exp(1'b0, 32'h2002000A, 1'b0));
    if_addr = 32'h8; if_req = 1'b1;
    wait_ack(300, ok, gi, gd, ge, ri, rd);
    if_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!ok || gi !== 1'b1 || ri !== e.rdata || ge !== e.err) begin
      errors++; $display("FAIL reset_mid_next: ok=%0b if_ack=%b got %h expected %h", ok, gi, ri, e.rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_BYTES); i++) ram[i] = 8'(i);
    {ram[8], ram[9], ram[10], ram[11]} = 32'h2002000A;
    @(negedge clk);
    test_reset();
    test_if_read();
    test_priority();
`ifdef ROUND_ROBIN_EN
    test_round_robin();
`endif
    test_byte_rw();
    test_errors();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
